// File: rtl/qnigma_mdio_ctrl.sv
// qnigma_mdio_ctrl: PHY bring-up and status-poll sequencer in front of the MDIO serial engine.
// Brings the PHY out of power-up, soft-resets it, writes advertisement and restarts
// autonegotiation. It then polls link/speed/duplex forever and presents them as registered status.
// Ports:
//   clk, rst (sync, active-high), restart (pulse: re-run init from power-up wait)
//   mdio_send/r_nw/phyad/regad/wdat : one transaction request to the engine
//   mdio_ready/done/rd_val/rdat     : engine handshake and read data
//   init_done, init_err             : bring-up result
//   link_up, speed, full_duplex     : PHY status, updated together
//   status_chg                      : one-cycle pulse when the status tuple changes
module qnigma_mdio_ctrl #(
    parameter logic [4:0]  PHY_ADDR    = 5'd1,
    parameter int unsigned POWERUP_CYC = 100000,
    parameter int unsigned POLL_CYC    = 1000000,
    parameter int unsigned TXN_TIMEOUT = 65535,
    parameter int unsigned SRST_TRIES  = 16,
    parameter logic [15:0] ANAR_VAL    = 16'h01E1,
    parameter logic [15:0] BMCR_AN     = 16'h1200,
    parameter logic [4:0]  STS_REG     = 5'd17,
    parameter int unsigned SPD_LSB     = 14,
    parameter int unsigned DPX_BIT     = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    output logic        mdio_send,
    output logic        mdio_r_nw,
    output logic [4:0]  mdio_phyad,
    output logic [4:0]  mdio_regad,
    output logic [15:0] mdio_wdat,
    input  logic        mdio_ready,
    input  logic        mdio_done,
    input  logic        mdio_rd_val,
    input  logic [15:0] mdio_rdat,
    output logic        init_done,
    output logic        init_err,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        full_duplex,
    output logic        status_chg
);

    localparam int unsigned WAIT_MAX = (POWERUP_CYC > POLL_CYC) ? POWERUP_CYC : POLL_CYC;
    localparam int unsigned WCNT_W   = $clog2(WAIT_MAX + 1);
    localparam int unsigned TCNT_W   = $clog2(TXN_TIMEOUT + 1);
    localparam int unsigned TRY_W    = $clog2(SRST_TRIES + 1);

    localparam logic [3:0] PWR_WAIT  = 4'd0;
    localparam logic [3:0] SRST_WR   = 4'd1;
    localparam logic [3:0] SRST_RD   = 4'd2;
    localparam logic [3:0] ANAR_WR   = 4'd3;
    localparam logic [3:0] AN_WR     = 4'd4;
    localparam logic [3:0] BMSR_RD1  = 4'd5;
    localparam logic [3:0] BMSR_RD2  = 4'd6;
    localparam logic [3:0] STS_RD    = 4'd7;
    localparam logic [3:0] UPDATE    = 4'd8;
    localparam logic [3:0] POLL_WAIT = 4'd9;
    localparam logic [3:0] FAULT     = 4'd10;

    logic [3:0]        state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic [TCNT_W-1:0] tcnt, tcnt_nxt;
    logic [TRY_W-1:0]  tries, tries_nxt;
    logic              in_wait, in_wait_nxt;
    logic              send_nxt, r_nw_nxt;
    logic [4:0]        phyad_nxt, regad_nxt;
    logic [15:0]       wdat_nxt;
    logic              init_done_nxt, init_err_nxt;
    logic              link_nxt, dpx_nxt, chg_nxt;
    logic [1:0]        speed_nxt;
    logic              new_link, new_link_nxt, new_dpx, new_dpx_nxt;
    logic [1:0]        new_spd, new_spd_nxt;
    logic              txn_done;
    logic              acc_en, acc_rnw;
    logic [4:0]        acc_reg;
    logic [15:0]       acc_dat;
    logic [1:0]        upd_spd;
    logic              upd_dpx;
    logic              rdat_unused;

    assign rdat_unused = ^mdio_rdat;

    // With link down the speed/duplex fields are meaningless, so report them as zero.
    assign upd_spd = new_link ? new_spd : 2'b00;
    assign upd_dpx = new_link & new_dpx;

    // Transaction descriptor for each access state.
    always_comb begin
        acc_en  = 1'b1;
        acc_rnw = 1'b1;
        acc_reg = 5'd0;
        acc_dat = 16'h0000;
        case (state)
            SRST_WR:  begin acc_rnw = 1'b0; acc_dat = 16'h8000; end
            SRST_RD:  acc_reg = 5'd0;
            ANAR_WR:  begin acc_rnw = 1'b0; acc_reg = 5'd4; acc_dat = ANAR_VAL; end
            AN_WR:    begin acc_rnw = 1'b0; acc_dat = BMCR_AN; end
            BMSR_RD1: acc_reg = 5'd1;
            BMSR_RD2: acc_reg = 5'd1;
            STS_RD:   acc_reg = STS_REG;
            default:  acc_en = 1'b0;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        wcnt_nxt      = wcnt;
        tcnt_nxt      = tcnt;
        tries_nxt     = tries;
        in_wait_nxt   = in_wait;
        send_nxt      = 1'b0;
        r_nw_nxt      = mdio_r_nw;
        phyad_nxt     = mdio_phyad;
        regad_nxt     = mdio_regad;
        wdat_nxt      = mdio_wdat;
        init_done_nxt = init_done;
        init_err_nxt  = init_err;
        link_nxt      = link_up;
        speed_nxt     = speed;
        dpx_nxt       = full_duplex;
        chg_nxt       = 1'b0;
        new_link_nxt  = new_link;
        new_spd_nxt   = new_spd;
        new_dpx_nxt   = new_dpx;
        txn_done      = 1'b0;

        if (restart) begin
            // Abandon everything; an engine done still in flight lands outside WAIT and is dropped.
            state_nxt     = PWR_WAIT;
            wcnt_nxt      = '0;
            tcnt_nxt      = '0;
            tries_nxt     = '0;
            in_wait_nxt   = 1'b0;
            init_done_nxt = 1'b0;
            init_err_nxt  = 1'b0;
            link_nxt      = 1'b0;
            speed_nxt     = 2'b00;
            dpx_nxt       = 1'b0;
            new_link_nxt  = 1'b0;
            new_spd_nxt   = 2'b00;
            new_dpx_nxt   = 1'b0;
        end else if (acc_en) begin
            if (!in_wait) begin
                if (mdio_ready) begin
                    send_nxt    = 1'b1;
                    in_wait_nxt = 1'b1;
                    tcnt_nxt    = '0;
                    r_nw_nxt    = acc_rnw;
                    phyad_nxt   = PHY_ADDR;
                    regad_nxt   = acc_reg;
                    wdat_nxt    = acc_dat;
                end
            end else if (mdio_done) begin
                // Done wins over a timeout landing in the same cycle.
                in_wait_nxt = 1'b0;
                txn_done    = 1'b1;
            end else if (tcnt == TCNT_W'(TXN_TIMEOUT - 1)) begin
                in_wait_nxt   = 1'b0;
                state_nxt     = FAULT;
                init_err_nxt  = 1'b1;
                init_done_nxt = 1'b0;
            end else begin
                tcnt_nxt = tcnt + TCNT_W'(1);
            end

            if (txn_done) begin
                case (state)
                    SRST_WR: begin
                        tries_nxt = '0;
                        state_nxt = SRST_RD;
                    end
                    SRST_RD: begin
                        if (mdio_rd_val && !mdio_rdat[15]) begin
                            state_nxt = ANAR_WR;
                        end else if (tries == TRY_W'(SRST_TRIES - 1)) begin
                            state_nxt     = FAULT;
                            init_err_nxt  = 1'b1;
                            init_done_nxt = 1'b0;
                        end else begin
                            tries_nxt = tries + TRY_W'(1);
                        end
                    end
                    ANAR_WR: state_nxt = AN_WR;
                    AN_WR: begin
                        init_done_nxt = 1'b1;
                        state_nxt     = BMSR_RD1;
                    end
                    BMSR_RD1: state_nxt = BMSR_RD2;
                    BMSR_RD2: begin
                        if (mdio_rd_val) new_link_nxt = mdio_rdat[2];
                        state_nxt = STS_RD;
                    end
                    STS_RD: begin
                        if (mdio_rd_val) begin
                            new_spd_nxt = mdio_rdat[SPD_LSB +: 2];
                            new_dpx_nxt = mdio_rdat[DPX_BIT];
                        end
                        state_nxt = UPDATE;
                    end
                    default: state_nxt = state;
                endcase
            end
        end else begin
            case (state)
                PWR_WAIT: begin
                    if (wcnt == WCNT_W'(POWERUP_CYC - 1)) begin
                        wcnt_nxt  = '0;
                        state_nxt = SRST_WR;
                    end else begin
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end
                end
                POLL_WAIT: begin
                    if (wcnt == WCNT_W'(POLL_CYC - 1)) begin
                        wcnt_nxt  = '0;
                        state_nxt = BMSR_RD1;
                    end else begin
                        wcnt_nxt = wcnt + WCNT_W'(1);
                    end
                end
                UPDATE: begin
                    link_nxt  = new_link;
                    speed_nxt = upd_spd;
                    dpx_nxt   = upd_dpx;
                    chg_nxt   = ({new_link, upd_spd, upd_dpx} != {link_up, speed, full_duplex});
                    wcnt_nxt  = '0;
                    state_nxt = POLL_WAIT;
                end
                FAULT: begin
                    init_err_nxt  = 1'b1;
                    init_done_nxt = 1'b0;
                end
                default: state_nxt = PWR_WAIT;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PWR_WAIT;
            wcnt        <= '0;
            tcnt        <= '0;
            tries       <= '0;
            in_wait     <= 1'b0;
            mdio_send   <= 1'b0;
            mdio_r_nw   <= 1'b0;
            mdio_phyad  <= 5'd0;
            mdio_regad  <= 5'd0;
            mdio_wdat   <= 16'h0000;
            init_done   <= 1'b0;
            init_err    <= 1'b0;
            link_up     <= 1'b0;
            speed       <= 2'b00;
            full_duplex <= 1'b0;
            status_chg  <= 1'b0;
            new_link    <= 1'b0;
            new_spd     <= 2'b00;
            new_dpx     <= 1'b0;
        end else begin
            state       <= state_nxt;
            wcnt        <= wcnt_nxt;
            tcnt        <= tcnt_nxt;
            tries       <= tries_nxt;
            in_wait     <= in_wait_nxt;
            mdio_send   <= send_nxt;
            mdio_r_nw   <= r_nw_nxt;
            mdio_phyad  <= phyad_nxt;
            mdio_regad  <= regad_nxt;
            mdio_wdat   <= wdat_nxt;
            init_done   <= init_done_nxt;
            init_err    <= init_err_nxt;
            link_up     <= link_nxt;
            speed       <= speed_nxt;
            full_duplex <= dpx_nxt;
            status_chg  <= chg_nxt;
            new_link    <= new_link_nxt;
            new_spd     <= new_spd_nxt;
            new_dpx     <= new_dpx_nxt;
        end
    end

endmodule

// File: tb/tb_qnigma_mdio_ctrl.sv
// Testbench for qnigma_mdio_ctrl: behavioural MDIO engine + PHY model, directed scenarios.
`timescale 1ns/1ps
module tb_qnigma_mdio_ctrl;

    localparam int unsigned POWERUP = 20;
    localparam int unsigned POLL    = 100;
    localparam int unsigned TMO     = 50;
    localparam int unsigned TRIES   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        restart;
    logic        mdio_send, mdio_r_nw;
    logic [4:0]  mdio_phyad, mdio_regad;
    logic [15:0] mdio_wdat;
    logic        mdio_ready, mdio_done, mdio_rd_val;
    logic [15:0] mdio_rdat;
    logic        init_done, init_err, link_up, full_duplex, status_chg;
    logic [1:0]  speed;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model configuration, written only by the main sequence.
    int          lat = 3;
    bit          suppress_done = 1'b0;
    int          bmcr_busy_reads = 2;
    logic [15:0] bmsr1 = 16'h7809;
    logic [15:0] bmsr2 = 16'h780D;
    logic [15:0] sts_val = 16'hAC00;
    int          sync_req = 0;

    // Model-owned state and transaction log.
    int          sync_ack = 0;
    int          r0_seen = 0;
    bit          bmsr_sel = 1'b0;
    bit          busy = 1'b0;
    int          cnt = 0;
    bit          cur_rnw = 1'b0;
    logic [15:0] resp = 16'h0;
    int          last_send_cyc = 0;
    int          last_done_cyc = 0;
    int          proto_viol = 0;
    bit          log_rnw[$];
    logic [4:0]  log_reg[$];
    logic [15:0] log_dat[$];
    int          log_cyc[$];

    qnigma_mdio_ctrl #(
        .PHY_ADDR(5'd1), .POWERUP_CYC(POWERUP), .POLL_CYC(POLL), .TXN_TIMEOUT(TMO),
        .SRST_TRIES(TRIES), .ANAR_VAL(16'h01E1), .BMCR_AN(16'h1200), .STS_REG(5'd17),
        .SPD_LSB(14), .DPX_BIT(13)
    ) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .mdio_send(mdio_send), .mdio_r_nw(mdio_r_nw), .mdio_phyad(mdio_phyad),
        .mdio_regad(mdio_regad), .mdio_wdat(mdio_wdat), .mdio_ready(mdio_ready),
        .mdio_done(mdio_done), .mdio_rd_val(mdio_rd_val), .mdio_rdat(mdio_rdat),
        .init_done(init_done), .init_err(init_err), .link_up(link_up), .speed(speed),
        .full_duplex(full_duplex), .status_chg(status_chg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine + PHY model: accepts a send, stays busy for lat cycles, then pulses done.
    initial begin
        mdio_ready = 1'b1; mdio_done = 1'b0; mdio_rd_val = 1'b0; mdio_rdat = 16'h0;
        forever begin
            @(negedge clk);
            if (sync_ack != sync_req) begin
                sync_ack = sync_req; r0_seen = 0; bmsr_sel = 1'b0;
            end
            mdio_done = 1'b0; mdio_rd_val = 1'b0;
            if (mdio_send) begin
                log_rnw.push_back(mdio_r_nw); log_reg.push_back(mdio_regad);
                log_dat.push_back(mdio_wdat); log_cyc.push_back(cyc);
                last_send_cyc = cyc;
                if (!mdio_ready || mdio_phyad != 5'd1) proto_viol++;
                cur_rnw = mdio_r_nw;
                resp = 16'h0000;
                if (mdio_r_nw) begin
                    if (mdio_regad == 5'd0) begin
                        resp = (r0_seen < bmcr_busy_reads) ? 16'h8000 : 16'h1140;
                        r0_seen++;
                    end else if (mdio_regad == 5'd1) begin
                        resp = bmsr_sel ? bmsr2 : bmsr1;
                        bmsr_sel = ~bmsr_sel;
                    end else if (mdio_regad == 5'd17) begin
                        resp = sts_val;
                    end
                end
                if (!suppress_done) begin busy = 1'b1; cnt = lat; end
            end else if (busy) begin
                if (cnt == 0) begin
                    busy = 1'b0; mdio_done = 1'b1; mdio_rd_val = cur_rnw;
                    mdio_rdat = cur_rnw ? resp : 16'h0000;
                    last_done_cyc = cyc;
                end else begin
                    cnt--;
                end
            end
            mdio_ready = !busy && !mdio_done;
        end
    end

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        sync_req++;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({init_done, init_err, link_up, speed, full_duplex, status_chg} !== 7'b0) begin
            errors++; $display("FAIL reset_status: got %b expected 0000000",
                {init_done, init_err, link_up, speed, full_duplex, status_chg});
        end
        checks++; if (mdio_send !== 1'b0) begin
            errors++; $display("FAIL reset_send: got %b expected 0", mdio_send);
        end
        checks++; if ({mdio_r_nw, mdio_phyad, mdio_regad, mdio_wdat} !== 27'b0) begin
            errors++; $display("FAIL reset_bus: got %h expected 0", {mdio_r_nw, mdio_phyad, mdio_regad, mdio_wdat});
        end
        rst = 1'b0;
    endtask

    task automatic test_init();
        bit          seen = 1'b0;
        bit          e_rnw [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0]  e_reg [6] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0};
        logic [15:0] e_dat [6] = '{16'h8000, 16'h0, 16'h0, 16'h0, 16'h01E1, 16'h1200};
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (init_done) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL init_done_timeout: got 0 expected 1"); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= log_reg.size()) begin
                errors++; $display("FAIL init_seq[%0d]: got no transaction expected one", i);
            end else if (log_rnw[i] !== e_rnw[i] || log_reg[i] !== e_reg[i] ||
                         (!e_rnw[i] && log_dat[i] !== e_dat[i])) begin
                errors++; $display("FAIL init_seq[%0d]: got rnw=%b reg=%0d dat=%h expected rnw=%b reg=%0d dat=%h",
                    i, log_rnw[i], log_reg[i], log_dat[i], e_rnw[i], e_reg[i], e_dat[i]);
            end
        end
    endtask

    task automatic test_status();
        bit seen = 1'b0;
        int n0;
        int chg = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (status_chg) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL status_chg_timeout: got 0 expected 1"); end
        checks++; if ({link_up, speed, full_duplex} !== 4'b1101) begin
            errors++; $display("FAIL status_tuple: got %b expected 1101", {link_up, speed, full_duplex});
        end
        n0 = log_reg.size();
        @(negedge clk);
        checks++; if (status_chg !== 1'b0) begin
            errors++; $display("FAIL status_chg_width: got %b expected 0", status_chg);
        end
        repeat (89) begin @(negedge clk); if (status_chg) chg++; end
        checks++; if (log_reg.size() != n0) begin
            errors++; $display("FAIL poll_wait_quiet: got %0d sends expected 0", log_reg.size() - n0);
        end
        repeat (60) begin @(negedge clk); if (status_chg) chg++; end
        checks++; if (log_reg.size() != n0 + 3) begin
            errors++; $display("FAIL poll_round_len: got %0d sends expected 3", log_reg.size() - n0);
        end else begin
            checks++; if (!(log_rnw[n0] && log_reg[n0] == 5'd1 && log_rnw[n0+1] && log_reg[n0+1] == 5'd1 &&
                            log_rnw[n0+2] && log_reg[n0+2] == 5'd17)) begin
                errors++; $display("FAIL poll_round_regs: got %0d,%0d,%0d expected 1,1,17",
                    log_reg[n0], log_reg[n0+1], log_reg[n0+2]);
            end
        end
        checks++; if (chg != 0) begin errors++; $display("FAIL same_tuple_chg: got %0d pulses expected 0", chg); end
    endtask

    task automatic test_restart_mid_txn();
        bit seen = 1'b0;
        int n0, rst_cyc, d;
        lat = 40;
        n0 = log_reg.size();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (log_reg.size() > n0 && log_reg[log_reg.size()-1] == 5'd1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL bmsr_send_timeout: got none expected R1"); end
        repeat (5) @(negedge clk);
        restart = 1'b1;
        sync_req++;
        rst_cyc = cyc;
        n0 = log_reg.size();
        @(negedge clk);
        restart = 1'b0;
        lat = 3;
        checks++; if ({init_done, link_up, speed, full_duplex} !== 5'b0) begin
            errors++; $display("FAIL restart_clear: got %b expected 00000", {init_done, link_up, speed, full_duplex});
        end
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (log_reg.size() > n0) begin seen = 1'b1; break; end
        end
        d = last_done_cyc;
        checks++; if (!seen) begin
            errors++; $display("FAIL restart_send_timeout: got none expected W0");
        end else begin
            checks++; if (log_rnw[n0] !== 1'b0 || log_reg[n0] !== 5'd0 || log_dat[n0] !== 16'h8000) begin
                errors++; $display("FAIL restart_first_txn: got rnw=%b reg=%0d dat=%h expected W0=8000",
                    log_rnw[n0], log_reg[n0], log_dat[n0]);
            end
            checks++; if (!(d > rst_cyc && log_cyc[n0] > d)) begin
                errors++; $display("FAIL restart_wait_ready: got send@%0d done@%0d expected send after late done",
                    log_cyc[n0], d);
            end
        end
        checks++; if (link_up !== 1'b0 || init_done !== 1'b0) begin
            errors++; $display("FAIL late_done_ignored: got link=%b init=%b expected 0 0", link_up, init_done);
        end
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (status_chg) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || {init_done, link_up, speed, full_duplex} !== 5'b11101) begin
            errors++; $display("FAIL reinit_status: got %b expected 11101", {init_done, link_up, speed, full_duplex});
        end
    endtask

    task automatic test_link_drop();
        bit seen = 1'b0;
        bmsr2 = 16'h7809;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (status_chg) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL link_drop_chg: got 0 expected 1"); end
        checks++; if ({link_up, speed, full_duplex} !== 4'b0000) begin
            errors++; $display("FAIL link_drop_tuple: got %b expected 0000", {link_up, speed, full_duplex});
        end
    endtask

    task automatic test_srst_stuck();
        bit seen = 1'b0;
        int n0, reads = 0;
        bmcr_busy_reads = 1000;
        n0 = log_reg.size();
        pulse_restart();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (init_err) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || init_done !== 1'b0) begin
            errors++; $display("FAIL stuck_fault: got err=%b done=%b expected 1 0", init_err, init_done);
        end
        for (int i = n0; i < log_reg.size(); i++) if (log_rnw[i] && log_reg[i] == 5'd0) reads++;
        checks++; if (reads != 4 || log_reg.size() != n0 + 5) begin
            errors++; $display("FAIL stuck_reads: got %0d R0 of %0d txns expected 4 of 5", reads, log_reg.size() - n0);
        end
        n0 = log_reg.size();
        repeat (100) @(negedge clk);
        checks++; if (log_reg.size() != n0 || init_err !== 1'b1) begin
            errors++; $display("FAIL fault_quiet: got %0d sends err=%b expected 0 1", log_reg.size() - n0, init_err);
        end
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        int n0, err_cyc = 0;
        bmcr_busy_reads = 0;
        suppress_done = 1'b1;
        n0 = log_reg.size();
        pulse_restart();
        checks++; if (init_err !== 1'b0) begin
            errors++; $display("FAIL restart_clears_err: got %b expected 0", init_err);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (init_err) begin seen = 1'b1; err_cyc = cyc; break; end
        end
        checks++; if (!seen || err_cyc - last_send_cyc != 50) begin
            errors++; $display("FAIL timeout_latency: got %0d cycles expected 50", err_cyc - last_send_cyc);
        end
        checks++; if (log_reg.size() != n0 + 1 || log_dat[log_dat.size()-1] !== 16'h8000) begin
            errors++; $display("FAIL timeout_txn: got %0d sends expected 1 (W0=8000)", log_reg.size() - n0);
        end
        suppress_done = 1'b0;
        pulse_restart();
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (init_done) begin seen = 1'b1; break; end
        end
        checks++; if (!seen || init_err !== 1'b0) begin
            errors++; $display("FAIL timeout_recover: got done=%b err=%b expected 1 0", init_done, init_err);
        end
    endtask

    initial begin
        rst = 1'b1;
        restart = 1'b0;
        test_reset();
        test_init();
        test_status();
        test_restart_mid_txn();
        test_link_drop();
        test_srst_stuck();
        test_timeout();
        checks++; if (proto_viol != 0) begin
            errors++; $display("FAIL send_protocol: got %0d violations expected 0", proto_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
